// File: rtl/mdu_hilo_ctrl.sv
// mdu_hilo_ctrl: multiply/divide sequencer and owner of the HI/LO registers.
// A multiply drives operand magnitudes to an external combinational multiplier
// and captures the sign-corrected product once the adder tree has settled.
// A divide runs an internal 32-step restoring divider, one step per clock.
module mdu_hilo_ctrl #(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES);
    localparam logic [5:0] DIV_LOAD = 6'd32;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic        neg_q, neg_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        dz_q, dz_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] quot_q, quot_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    // Divider datapath for one restoring step
    logic [32:0] rem_shift;
    logic [33:0] trial;
    logic        trial_ok;
    logic [32:0] rem_step;
    logic [31:0] quot_step;

    logic        op_signed;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [63:0] product_fix;

    // Magnitude of a 32-bit operand when it is treated as signed;
    // 0x80000000 maps to itself, which reads correctly as unsigned.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        logic [31:0] r;
        r = (sgn && v[31]) ? (~v + 32'd1) : v;
        return r;
    endfunction

    // Operand conditioning and one restoring-division step from current state
    always_comb begin
        op_signed   = op[0];
        rs_mag      = magnitude(rs_val, op_signed);
        rt_mag      = magnitude(rt_val, op_signed);
        product_fix = neg_q ? (~mul_result + 64'd1) : mul_result;

        rem_shift   = {rem_q[31:0], quot_q[31]};
        trial       = {1'b0, rem_shift} - {2'b00, divisor_q};
        trial_ok    = ~trial[33];
        rem_step    = trial_ok ? trial[32:0] : rem_shift;
        quot_step   = {quot_q[30:0], trial_ok};
    end

    // Next-state and register-update logic for the sequencer
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        neg_d     = neg_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dz_d      = dz_q;
        divisor_d = divisor_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULTU, OP_MULT: begin
                            mul_a_d = rs_mag;
                            mul_b_d = rt_mag;
                            neg_d   = op_signed && (rs_val[31] ^ rt_val[31]);
                            cnt_d   = MUL_LOAD;
                            state_d = MUL;
                        end
                        OP_DIVU, OP_DIV: begin
                            quot_d    = rs_mag;
                            divisor_d = rt_mag;
                            qneg_d    = op_signed && (rs_val[31] ^ rt_val[31]);
                            rneg_d    = op_signed && rs_val[31];
                            dz_d      = (rt_val == 32'd0);
                            rem_d     = 33'd0;
                            cnt_d     = DIV_LOAD;
                            state_d   = DIV;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end

            MUL: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    hi_d    = product_fix[63:32];
                    lo_d    = product_fix[31:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            DIV: begin
                cnt_d  = cnt_q - 6'd1;
                rem_d  = rem_step;
                quot_d = quot_step;
                if (cnt_q == 6'd1) begin
                    // A zero divisor leaves the quotient all ones and the
                    // remainder equal to the dividend magnitude; the remainder
                    // sign fix restores rs_val, but LO must ignore the sign.
                    if (dz_q) begin
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        lo_d = qneg_q ? (~quot_step + 32'd1) : quot_step;
                    end
                    hi_d    = rneg_q ? (~rem_step[31:0] + 32'd1) : rem_step[31:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            mul_a_q   <= 32'd0;
            mul_b_q   <= 32'd0;
            neg_q     <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            divisor_q <= 32'd0;
            quot_q    <= 32'd0;
            rem_q     <= 33'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            neg_q     <= neg_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dz_q      <= dz_d;
            divisor_q <= divisor_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// tb_mdu_hilo_ctrl: drives directed and random MDU requests and compares
// HI/LO, busy latency, done and the multiplier operand bus against an
// arithmetic reference model.
module tb_mdu_hilo_ctrl;

    localparam int unsigned MUL_CYC = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_result;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vecCount = 0;
    int errCount = 0;

    logic [31:0] modelHi = 32'd0;
    logic [31:0] modelLo = 32'd0;

    mdu_hilo_ctrl #(.MUL_CYCLES(MUL_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    // Stand-in for the external combinational unsigned multiplier
    assign mul_result = 64'(mul_a) * 64'(mul_b);

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour computed directly from the instruction semantics
    task automatic refModel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            output int lat, output logic [31:0] expA, output logic [31:0] expB);
        logic signed [63:0] sp;
        int sa;
        int sb;
        lat  = 0;
        expA = 32'd0;
        expB = 32'd0;
        sa   = a;
        sb   = b;
        case (o)
            3'b000: begin
                {modelHi, modelLo} = 64'(a) * 64'(b);
                expA = a;
                expB = b;
                lat  = int'(MUL_CYC);
            end
            3'b001: begin
                sp = 64'(sa) * 64'(sb);
                {modelHi, modelLo} = sp;
                expA = (sa < 0) ? 32'(-sa) : a;
                expB = (sb < 0) ? 32'(-sb) : b;
                lat  = int'(MUL_CYC);
            end
            3'b010: begin
                if (b == 0) begin
                    modelLo = 32'hFFFF_FFFF;
                    modelHi = a;
                end else begin
                    modelLo = a / b;
                    modelHi = a % b;
                end
                lat = 32;
            end
            3'b011: begin
                if (b == 0) begin
                    modelLo = 32'hFFFF_FFFF;
                    modelHi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    modelLo = 32'h8000_0000;
                    modelHi = 32'd0;
                end else begin
                    modelLo = 32'(sa / sb);
                    modelHi = 32'(sa % sb);
                end
                lat = 32;
            end
            3'b100: modelHi = a;
            3'b101: modelLo = a;
            default: ;
        endcase
    endtask

    // Issue one request (current time is just after a rising edge) and follow
    // it to completion; returns in the done cycle so the next call issues
    // back-to-back with no bubble.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input bit pokeWhileBusy);
        int lat;
        int cycles;
        logic [31:0] expA;
        logic [31:0] expB;
        logic [31:0] prevA;
        logic [31:0] prevB;
        prevA = mul_a;
        prevB = mul_b;
        refModel(o, a, b, lat, expA, expB);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        checkOutput("done_after_accept", 64'(done), 64'd0);
        if (lat == 0) begin
            checkOutput("busy_mt", 64'(busy), 64'd0);
            checkOutput("mul_a_hold", 64'(mul_a), 64'(prevA));
            checkOutput("mul_b_hold", 64'(mul_b), 64'(prevB));
        end else begin
            checkOutput("busy_issue", 64'(busy), 64'd1);
            if (o[2:1] == 2'b00) begin
                checkOutput("mul_a", 64'(mul_a), 64'(expA));
                checkOutput("mul_b", 64'(mul_b), 64'(expB));
            end
            cycles = 0;
            while (busy && cycles < 100) begin
                if (pokeWhileBusy && cycles == 0) begin
                    start  = 1'b1;
                    op     = 3'b100;
                    rs_val = $urandom;
                    rt_val = $urandom;
                end
                @(posedge clk);
                #1;
                start = 1'b0;
                cycles++;
            end
            checkOutput("busy_cycles", 64'(cycles), 64'(lat));
            checkOutput("done_pulse", 64'(done), 64'd1);
            if (o[2:1] == 2'b00) begin
                checkOutput("mul_a_stable", 64'(mul_a), 64'(expA));
            end
        end
        checkOutput("hi", 64'(hi), 64'(modelHi));
        checkOutput("lo", 64'(lo), 64'(modelLo));
    endtask

    // Pick operands biased toward the interesting corners
    function automatic logic [31:0] pickOperand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'($urandom_range(1, 20));
            4: v = 32'(-$urandom_range(1, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Main sequence: reset, directed cases, mid-divide reset, random traffic
    initial begin
        start  = 1'b0;
        op     = 3'b000;
        rs_val = 32'd0;
        rt_val = 32'd0;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_hi", 64'(hi), 64'd0);
        checkOutput("rst_lo", 64'(lo), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_mul_a", 64'(mul_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed cases");
        applyStimulus(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        checkOutput("multu_hi_const", 64'(hi), 64'hFFFF_FFFE);
        checkOutput("multu_lo_const", 64'(lo), 64'h0000_0001);
        applyStimulus(3'b001, 32'hFFFF_FFFD, 32'd5, 1'b0);
        checkOutput("mult_hi_const", 64'(hi), 64'hFFFF_FFFF);
        checkOutput("mult_lo_const", 64'(lo), 64'hFFFF_FFF1);
        applyStimulus(3'b010, 32'd100, 32'd7, 1'b0);
        checkOutput("divu_lo_const", 64'(lo), 64'd14);
        checkOutput("divu_hi_const", 64'(hi), 64'd2);
        applyStimulus(3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0);
        checkOutput("div_lo_const", 64'(lo), 64'hFFFF_FFFD);
        checkOutput("div_hi_const", 64'(hi), 64'hFFFF_FFFF);
        applyStimulus(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        checkOutput("ovf_lo_const", 64'(lo), 64'h8000_0000);
        checkOutput("ovf_hi_const", 64'(hi), 64'd0);
        applyStimulus(3'b011, 32'hFFFF_FFF0, 32'd0, 1'b0);
        checkOutput("dz_lo_const", 64'(lo), 64'hFFFF_FFFF);
        checkOutput("dz_hi_const", 64'(hi), 64'hFFFF_FFF0);
        applyStimulus(3'b000, 32'd6, 32'd7, 1'b0);
        checkOutput("b2b_lo1_const", 64'(lo), 64'd42);
        applyStimulus(3'b010, 32'd9, 32'd4, 1'b0);
        checkOutput("b2b_lo2_const", 64'(lo), 64'd2);
        checkOutput("b2b_hi2_const", 64'(hi), 64'd1);

        $display("[TB] reset during divide");
        start  = 1'b1;
        op     = 3'b010;
        rs_val = 32'hDEAD_BEEF;
        rt_val = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_hi", 64'(hi), 64'd0);
        checkOutput("midrst_lo", 64'(lo), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        modelHi = 32'd0;
        modelLo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(3'b101, 32'h0000_1234, 32'd0, 1'b0);
        checkOutput("mtlo_const", 64'(lo), 64'h0000_1234);

        $display("[TB] random traffic");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand(),
                          1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                checkOutput("idle_done", 64'(done), 64'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/mdu_hilo_ctrl.md
# mdu_hilo_ctrl

Multiply/divide sequencer and HI/LO register owner for the CPU's MULT, MULTU, DIV, DIVU, MTHI and MTLO instructions. It sits directly upstream of the combinational 32x32 unsigned multiplier:
- drives that multiplier's operands from registers;
- waits a programmable number of cycles for the deep adder tree to settle;
- sign-corrects and captures the 64-bit product into HI/LO.

Division uses an internal 32-cycle restoring divider. `busy` stalls the pipeline until HI/LO is valid.

## Interface
- `MUL_CYCLES`, default 2: cycles operands are held on `mul_a`/`mul_b` before the product is captured; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `start` in 1: issue request, sampled at the rising edge.
- `op` in 3: request type. 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO. 110 and 111 are no-ops.
- `rs_val` in 32: rs operand (dividend, or MTHI/MTLO source).
- `rt_val` in 32: rt operand (divisor).
- `mul_a` out 32: registered multiplier operand A, a magnitude.
- `mul_b` out 32: registered multiplier operand B, a magnitude.
- `mul_result` in 64: unsigned product returned by the multiplier.
- `busy` out 1: multiply or divide in flight; new `start` is ignored.
- `done` out 1: one-cycle pulse, HI/LO just updated by a multiply or divide.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- **States:** IDLE, MUL, DIV.
- **Reset (`rst_n`=0, any time including mid-operation):**
  - state goes to IDLE immediately;
  - `hi`, `lo`, `mul_a`, `mul_b`, internal counter, remainder and quotient all clear to 0;
  - `busy` = 0 and `done` = 0;
  - any in-flight operation is discarded.
- **Accepting requests:** `start` is accepted only in IDLE. In MUL or DIV, `start` is ignored and no state changes.
- **MTHI / MTLO:** `hi` (or `lo`) takes `rs_val` at the accepting edge. State stays IDLE; no `busy`, no `done`.
- **Signed operations (MULT, DIV):** operands are converted to magnitudes before use. `abs(0x80000000)` is 0x80000000 as an unsigned value.
- **MULT / MULTU, accepting edge:**
  - `mul_a` gets the magnitude of `rs_val`; `mul_b` gets the magnitude of `rt_val`;
  - `neg` = (op==MULT) && (`rs_val[31]` ^ `rt_val[31]`);
  - counter loads `MUL_CYCLES`; state goes to MUL.
- **MUL state:**
  - counter decrements each edge;
  - on the edge where the counter is 1: {`hi`,`lo`} gets `neg` ? (−`mul_result` mod 2^64) : `mul_result`;
  - state returns to IDLE and `done` is set.
- **DIV / DIVU, accepting edge:**
  - latch dividend magnitude and divisor magnitude;
  - `qneg` = signed && (sign bits differ); `rneg` = signed && `rs_val[31]`;
  - 33-bit remainder cleared; iteration counter set to 32; state goes to DIV.
- **DIV state:** one restoring step per edge, MSB first:
  - shift the remainder left and bring in the next dividend bit;
  - trial-subtract the divisor; if the result is non-negative, keep it and set the quotient bit to 1, else restore.
- **After step 32:**
  - `lo` gets the quotient, negated if `qneg`; `hi` gets the remainder, negated if `rneg`;
  - state returns to IDLE and `done` is set.
- **Divide by zero:** not trapped. It always takes 32 cycles and produces `lo` = 0xFFFFFFFF and `hi` = `rs_val` as originally issued, regardless of sign.
- **Overflow, 0x80000000 / −1 (DIV):** `lo` = 0x80000000, `hi` = 0.
- **Bus hold:** `mul_a` and `mul_b` hold their last values outside MUL.

## Timing
- Let E0 be the accepting edge.
- **`busy`:** high from after E0 until the result edge; combinationally equals (state != IDLE), so it is glitch-free as a registered state decode.
- **Multiply:** result edge is E`MUL_CYCLES`. After it, `hi`/`lo` are new, `done` = 1 and `busy` = 0.
- **Divide:** result edge is E32. After it, `hi`/`lo` are new, `done` = 1 and `busy` = 0.
- **`done`:** high for exactly one cycle and cleared at the next edge.
- **Back-to-back issue:** a new `start` is accepted at the edge ending the `done` cycle, giving zero bubble.
- **`mul_a`/`mul_b`:** stable from after E0 through the result edge. The multiplier path therefore has `MUL_CYCLES` full clock periods.
- **`hi`/`lo`:** change only at an MTHI/MTLO accepting edge or at a result edge. Readers (MFHI/MFLO) see registered values with zero extra latency.

## Test plan
- **Reset mid-divide:** issue DIVU, assert `rst_n`=0 at cycle 10 → `hi`=`lo`=0, `busy`=0, `done`=0 immediately. Then issue MTLO `rs_val`=0x1234 → `lo`=0x00001234 after one edge, with `busy` never high.
- **MULTU and stall:** `rs_val`=0xFFFFFFFF, `rt_val`=0xFFFFFFFF, `MUL_CYCLES`=2 → `busy` high exactly 2 cycles, then `hi`=0xFFFFFFFE, `lo`=0x00000001, and a one-cycle `done`. A `start` pulsed while `busy` is ignored.
- **MULT sign correction:** `rs_val`=0xFFFFFFFD (−3), `rt_val`=5 → `mul_a`=3, `mul_b`=5, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- **DIVU and DIV:**
  - DIVU 100/7 → after 32 cycles `lo`=14, `hi`=2.
  - DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Divide by zero:** DIV `rs_val`=0xFFFFFFF0, `rt_val`=0 → after 32 cycles `lo`=0xFFFFFFFF, `hi`=0xFFFFFFF0.
- **Back-to-back:** MULTU 6*7 then DIVU 9/4, with the second `start` held during the `done` cycle → `lo`=42 first, then the DIVU accepted with no gap, finishing with `lo`=2, `hi`=1.
